// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 memory slave.
//   state_e    : slave FSM states (IDLE = waiting for setup, ACCESS = access phase)
//   STRB_W     : byte lanes for the default 32-bit data bus
//   IDX_W      : word-index width for the default 16-word depth
//   RESP_*     : PSLVERR encoding
package apb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA  = 32;
   localparam int unsigned DEF_DEPTH = 16;
   localparam int unsigned STRB_W    = DEF_DATA / 8;
   localparam int unsigned IDX_W     = $clog2(DEF_DEPTH);

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/apb_strb_regfile.sv
// DEPTH x DATA register storage, cleared asynchronously by presetn.
//   pclk, presetn : clock and async active-low clear
//   we            : write enable (one word per cycle)
//   idx           : word index shared by the write and read ports
//   wstrb         : byte-lane enables for the write
//   wdata         : write data
//   rdata         : combinational read of word idx
module apb_strb_regfile
   import apb_pkg::*;
#(
   parameter int unsigned DATA  = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       pclk,
   input  logic                       presetn,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   idx,
   input  logic [DATA/8-1:0]          wstrb,
   input  logic [DATA-1:0]            wdata,
   output logic [DATA-1:0]            rdata
);

   localparam int unsigned LANES = DATA / 8;

   logic [DATA-1:0] mem_q [DEPTH];

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         // Unstrobed lanes keep their previous contents.
         for (int b = 0; b < int'(LANES); b++) begin
            if (wstrb[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 word-addressed register memory with byte strobes, programmable wait
// states and PSLVERR on out-of-range word indices.
//   pclk, presetn            : bus clock, async active-low reset
//   paddr                    : word index (not a byte address)
//   pwrite, pwdata, pstrb    : write control, data and byte-lane enables
//   psel, penable            : APB select and access-phase indicator
//   wait_cfg                 : wait states per transfer, sampled at setup
//   prdata, pready, pslverr  : APB response
module apb4_mem_slave
   import apb_pkg::*;
#(
   parameter int unsigned DATA   = 32,
   parameter int unsigned ADDR   = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned WAIT_W = 4
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic [ADDR-1:0]     paddr,
   input  logic                pwrite,
   input  logic [DATA-1:0]     pwdata,
   input  logic [DATA/8-1:0]   pstrb,
   input  logic                psel,
   input  logic                penable,
   input  logic [WAIT_W-1:0]   wait_cfg,
   output logic [DATA-1:0]     prdata,
   output logic                pready,
   output logic                pslverr
);

   localparam int unsigned IW = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              setup;
   logic              we;
   logic [DATA-1:0]   rdata;

   assign setup = psel & ~penable;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            // penable without a preceding setup is ignored here.
            if (setup) begin
               state_d = ACCESS;
               cnt_d   = wait_cfg;
               err_d   = (paddr >= ADDR'(DEPTH));
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_W'(1);
            end else if (setup) begin
               cnt_d = wait_cfg;
               err_d = (paddr >= ADDR'(DEPTH));
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign pready  = (state_q == ACCESS) && (cnt_q == '0) && psel && penable;
   assign pslverr = (pready && err_q) ? RESP_ERR : RESP_OKAY;
   assign we      = pready & pwrite & ~err_q;

   apb_strb_regfile #(
      .DATA  (DATA),
      .DEPTH (DEPTH)
   ) u_regfile (
      .pclk    (pclk),
      .presetn (presetn),
      .we      (we),
      .idx     (paddr[IW-1:0]),
      .wstrb   (pstrb),
      .wdata   (pwdata),
      .rdata   (rdata)
   );

   // Read data is only driven on a successful read completion.
   assign prdata = (pready && !pwrite && !err_q) ? rdata : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
module tb_apb4_mem_slave;

   logic        pclk;
   logic        presetn;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        psel;
   logic        penable;
   logic [3:0]  wait_cfg;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   apb4_mem_slave #(
      .DATA   (32),
      .ADDR   (32),
      .DEPTH  (16),
      .WAIT_W (4)
   ) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .paddr    (paddr),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .psel     (psel),
      .penable  (penable),
      .wait_cfg (wait_cfg),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: memory contents plus the response expected this cycle.
   logic [31:0] model_mem [16];
   logic        exp_pready;
   logic        exp_pslverr;
   logic [31:0] exp_prdata;
   logic        chk_en = 1'b0;

   task automatic set_exp(input logic rdy, input logic err, input logic [31:0] data);
      exp_pready  = rdy;
      exp_pslverr = err;
      exp_prdata  = data;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   always @(negedge pclk) begin
      if (chk_en) begin
         checks++;
         if ({pready, pslverr, prdata} !== {exp_pready, exp_pslverr, exp_prdata}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t: got rdy=%b err=%b rd=0x%08h expected rdy=%b err=%b rd=0x%08h",
                     $time, pready, pslverr, prdata, exp_pready, exp_pslverr, exp_prdata);
         end
      end
   end

   // Called just after a rising edge. Leaves psel/penable high on return so a
   // following call forms a back-to-back transfer.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int n,
                       output logic [31:0] rd, output logic er);
      logic in_range;
      in_range = (addr < 32'd16);
      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
      pwdata = data; pstrb = strb; wait_cfg = 4'(n);
      set_exp(1'b0, 1'b0, 32'h0);
      @(posedge pclk); #1;
      penable  = 1'b1;
      wait_cfg = ~(4'(n));  // must not disturb the transfer in flight
      for (int i = 0; i < n; i++) begin
         set_exp(1'b0, 1'b0, 32'h0);
         @(posedge pclk); #1;
      end
      set_exp(1'b1, !in_range, (!wr && in_range) ? model_mem[addr[3:0]] : 32'h0);
      @(negedge pclk);
      rd = prdata;
      er = pslverr;
      @(posedge pclk); #1;
      if (wr && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_mem[addr[3:0]][8*b +: 8] = data[8*b +: 8];
         end
      end
      set_exp(1'b0, 1'b0, 32'h0);
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0;
      set_exp(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk); #1;
      end
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
      presetn = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
      psel = 1'b0; penable = 1'b0; wait_cfg = '0;
      set_exp(1'b0, 1'b0, 32'h0);
      chk_en = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      check("reset_pready", {31'h0, pready}, 32'h0);
      check("reset_prdata", prdata, 32'h0);
      presetn = 1'b1;
      idle(2);

      // Protocol violation: penable without setup.
      penable = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b1;
      @(posedge pclk); #1;
      idle(1);

      // 1. zero wait states
      xfer(1'b1, 32'h0A, 32'h0000FACE, 4'hF, 0, rd, er); idle(1);
      xfer(1'b1, 32'h0B, 32'h0000BEEF, 4'hF, 0, rd, er); idle(1);
      xfer(1'b1, 32'h0C, 32'h0000CAFE, 4'hF, 0, rd, er); idle(1);
      xfer(1'b0, 32'h0A, 32'h0, 4'h0, 0, rd, er); idle(1);
      check("t1_rd_0a", rd, 32'h0000FACE);
      check("t1_err_0a", {31'h0, er}, 32'h0);
      xfer(1'b0, 32'h0B, 32'h0, 4'h0, 0, rd, er); idle(1);
      check("t1_rd_0b", rd, 32'h0000BEEF);
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, er); idle(1);
      check("t1_rd_0c", rd, 32'h0000CAFE);

      // 2. three wait states
      xfer(1'b1, 32'h05, 32'h0000F00D, 4'hF, 3, rd, er); idle(1);
      xfer(1'b0, 32'h05, 32'h0, 4'h0, 3, rd, er); idle(1);
      check("t2_rd_05", rd, 32'h0000F00D);

      // 3. byte strobes
      xfer(1'b1, 32'h02, 32'h11223344, 4'hF, 0, rd, er); idle(1);
      xfer(1'b1, 32'h02, 32'hAABBCCDD, 4'b0101, 1, rd, er); idle(1);
      xfer(1'b1, 32'h02, 32'hFFFFFFFF, 4'b0000, 0, rd, er); idle(1);
      check("t3_nostrb_err", {31'h0, er}, 32'h0);
      xfer(1'b0, 32'h02, 32'h0, 4'h0, 0, rd, er); idle(1);
      check("t3_rd_02", rd, 32'h11BB33DD);

      // 4. out of range
      xfer(1'b1, 32'h10, 32'h00001234, 4'hF, 0, rd, er); idle(1);
      check("t4_wr_err", {31'h0, er}, 32'h1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 2, rd, er); idle(1);
      check("t4_rd_err", {31'h0, er}, 32'h1);
      check("t4_rd_data", rd, 32'h0);
      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, 32'(i), 32'h0, 4'h0, 0, rd, er);
      end
      idle(1);
      xfer(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er); idle(1);
      check("t4_word0_intact", rd, 32'h0);

      // 5. back-to-back with psel held high
      xfer(1'b1, 32'h01, 32'h00005555, 4'hF, 0, rd, er);
      xfer(1'b0, 32'h01, 32'h0, 4'h0, 0, rd, er);
      check("t5_b2b_rd", rd, 32'h00005555);
      xfer(1'b0, 32'h0A, 32'h0, 4'h0, 1, rd, er); idle(1);
      check("t5_rd_0a", rd, 32'h0000FACE);

      // 6. reset in the wait phase of a write
      psel = 1'b1; penable = 1'b0; paddr = 32'h03; pwrite = 1'b1;
      pwdata = 32'h00009999; pstrb = 4'hF; wait_cfg = 4'd2;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      presetn = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
      #2;
      check("t6_rst_pready", {31'h0, pready}, 32'h0);
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      presetn = 1'b1;  // psel/penable still high: no setup, so no response
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      idle(1);
      xfer(1'b0, 32'h03, 32'h0, 4'h0, 0, rd, er); idle(1);
      check("t6_rd_03", rd, 32'h0);
      xfer(1'b0, 32'h0A, 32'h0, 4'h0, 0, rd, er); idle(2);
      check("t6_rd_0a_cleared", rd, 32'h0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
